// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the round-robin arbiter and its requester clients
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} arb_cli_state_t;

  // REQ and XFER are the only states in which req is asserted and grants count
  function automatic logic in_req_phase(arb_cli_state_t s);
    return (s == REQ) || (s == XFER);
  endfunction

endpackage

// File: rtl/arb_req_client_if.sv
// rtl/arb_req_client_if.sv - command and arbiter handshake bundle of one requester client
interface arb_req_client_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             req;
  logic             grant;
  logic             beat;
  logic [LEN_W-1:0] beat_idx;
  logic             done;

  modport master (
    output cmd_valid, cmd_len, grant,
    input  cmd_ready, req, beat, beat_idx, done
  );

  modport slave (
    input  cmd_valid, cmd_len, grant,
    output cmd_ready, req, beat, beat_idx, done
  );
endinterface

// File: rtl/arb_cmd_fifo.sv
// rtl/arb_cmd_fifo.sv - DEPTH x W synchronous command FIFO with full/empty flags
module arb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/arb_req_client.sv
// rtl/arb_req_client.sv - requester agent: queues bursts, requests the arbiter, counts beats, flags errors
module arb_req_client
  import arb_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  arb_req_client_if.slave   bus,
  input  logic              clr_err,
  output logic              busy,
  output logic              starve_err,
  output logic              spur_err
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  arb_cli_state_t    state_q, state_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              starve_q, starve_d;
  logic              spur_q, spur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LEN_W-1:0]  fifo_rdata;
  logic              beat, waiting, starve_set, spur_set;

  arb_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (LEN_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (bus.cmd_len),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_push     = bus.cmd_valid && !fifo_full;
  assign bus.cmd_ready = !fifo_full;
  assign bus.req       = req_q;
  assign bus.done      = done_q;
  assign bus.beat      = beat;
  assign bus.beat_idx  = idx_q;
  assign busy          = (state_q != IDLE) || !fifo_empty;
  assign starve_err    = starve_q;
  assign spur_err      = spur_q;

  // A grant seen in GAP is the arbiter lagging our dropped req, not a beat
  assign beat       = req_q && bus.grant && in_req_phase(state_q);
  assign waiting    = in_req_phase(state_q) && !bus.grant;
  assign starve_set = waiting && (wait_q >= WAIT_W'(TIMEOUT - 1));
  assign spur_set   = (state_q == IDLE) && bus.grant;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rem_d    = fifo_rdata;
          idx_d    = '0;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ, XFER: begin
        if (beat) begin
          if (rem_q == '0) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            rem_d   = rem_q - 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = XFER;
          end
        end
      end
      GAP: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wait_d = '0;
    if (waiting) wait_d = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + 1'b1;

    // Set wins over clear so a still-active fault cannot be cleared away
    starve_d = starve_set || (starve_q && !clr_err);
    spur_d   = spur_set   || (spur_q   && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      starve_q <= 1'b0;
      spur_q   <= 1'b0;
      rem_q    <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      done_q   <= done_d;
      starve_q <= starve_d;
      spur_q   <= spur_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
    end
  end

endmodule

// File: tb/tb_arb_req_client.sv
// tb/tb_arb_req_client.sv - four requester clients around a behavioural round-robin arbiter
module tb_arb_req_client;
  import arb_pkg::*;

  typedef struct {
    logic       v;
    logic [3:0] len;
    logic       g;
    logic       e_req;
    logic       e_beat;
    logic [3:0] e_idx;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmd_valid = '0;
  logic [3:0] cmd_len [4];
  logic [3:0] cmd_ready, req, grant, beat, done, busy, starve, spur;
  logic [3:0] beat_idx [4];
  logic [3:0] clr_err = '0;
  logic       force_en = 1'b1;
  logic [3:0] force_gnt = '0;
  logic [3:0] arb_gnt;
  int         arb_last;

  int checks = 0;
  int errors = 0;

  int  exp_len [4][$];
  int  beat_cnt [4];
  bit  pend_done [4];
  int  start_order [$];
  int  n_done, n_acc;
  bit  mon_en = 1'b0;
  bit  acc [4];

  always #5 clk = ~clk;

  assign grant = force_en ? force_gnt : arb_gnt;

  for (genvar g = 0; g < 4; g++) begin : cl
    arb_req_client_if #(.LEN_W(4)) bif ();
    assign bif.cmd_valid = cmd_valid[g];
    assign bif.cmd_len   = cmd_len[g];
    assign bif.grant     = grant[g];
    assign cmd_ready[g]  = bif.cmd_ready;
    assign req[g]        = bif.req;
    assign beat[g]       = bif.beat;
    assign beat_idx[g]   = bif.beat_idx;
    assign done[g]       = bif.done;
    arb_req_client #(.LEN_W(4), .DEPTH(4), .TIMEOUT(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bif.slave),
      .clr_err    (clr_err[g]),
      .busy       (busy[g]),
      .starve_err (starve[g]),
      .spur_err   (spur[g])
    );
  end

  // Registered round-robin arbiter: owner keeps grant while requesting, then rotate
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_gnt  <= '0;
      arb_last <= 3;
    end else if ((req & arb_gnt) == 4'b0) begin
      arb_gnt <= '0;
      for (int k = 4; k >= 1; k--) begin
        if (req[(arb_last + k) % 4]) begin
          arb_gnt  <= 4'b0001 << ((arb_last + k) % 4);
          arb_last <= (arb_last + k) % 4;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit v, int len, bit g, bit rq, bit bt, int idx, bit dn, bit bs);
    vec_t t;
    t.v = v; t.len = 4'(len); t.g = g; t.e_req = rq; t.e_beat = bt;
    t.e_idx = 4'(idx); t.e_done = dn; t.e_busy = bs;
    return t;
  endfunction

  // Scoreboard: each accepted command must produce len+1 beats indexed 0.., then one done
  initial forever begin : mon
    int nb;
    @(negedge clk);
    if (mon_en) begin
      nb = 0;
      for (int i = 0; i < 4; i++) begin
        if (cmd_valid[i] && cmd_ready[i]) begin
          exp_len[i].push_back(int'(cmd_len[i]));
          n_acc++;
        end
        chk($sformatf("done_c%0d", i), int'(done[i]), int'(pend_done[i]));
        if (done[i]) n_done++;
        pend_done[i] = 1'b0;
        if (beat[i]) begin
          nb++;
          chk($sformatf("beat_has_cmd_c%0d", i), int'(exp_len[i].size() != 0), 1);
          if (exp_len[i].size() != 0) begin
            chk($sformatf("beat_idx_c%0d", i), int'(beat_idx[i]), beat_cnt[i]);
            if (beat_cnt[i] == 0) start_order.push_back(i);
            beat_cnt[i]++;
            if (beat_cnt[i] == exp_len[i][0] + 1) begin
              pend_done[i] = 1'b1;
              beat_cnt[i]  = 0;
              void'(exp_len[i].pop_front());
            end
          end
        end
      end
      chk("beat_overlap", int'(nb <= 1), 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl [21];
    bit   found;
    for (int i = 0; i < 4; i++) cmd_len[i] = '0;

    tbl[0]  = mk(1, 3, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 1, 1, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 1, 1, 1, 1, 0, 1);
    tbl[5]  = mk(0, 0, 1, 1, 1, 2, 0, 1);
    tbl[6]  = mk(0, 0, 1, 1, 1, 3, 0, 1);
    tbl[7]  = mk(0, 0, 1, 0, 0, 0, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 4, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 1, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 1, 1, 1, 0, 1);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 1, 1, 1, 2, 0, 1);
    tbl[17] = mk(0, 0, 1, 1, 1, 3, 0, 1);
    tbl[18] = mk(0, 0, 1, 1, 1, 4, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) step();
    chk("rst_req", int'(req), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 15);
    chk("rst_busy", int'(busy), 0);
    chk("rst_starve", int'(starve), 0);
    chk("rst_spur", int'(spur), 0);
    rst_n = 1'b1;
    step();

    // Single burst then a paused burst on client 0, grant driven per cycle
    for (int r = 0; r < 21; r++) begin
      cmd_valid[0] = tbl[r].v;
      cmd_len[0]   = tbl[r].len;
      force_gnt    = {3'b000, tbl[r].g};
      #1;
      chk($sformatf("tbl%0d_req", r), int'(req[0]), int'(tbl[r].e_req));
      chk($sformatf("tbl%0d_beat", r), int'(beat[0]), int'(tbl[r].e_beat));
      chk($sformatf("tbl%0d_done", r), int'(done[0]), int'(tbl[r].e_done));
      chk($sformatf("tbl%0d_busy", r), int'(busy[0]), int'(tbl[r].e_busy));
      if (tbl[r].e_beat) chk($sformatf("tbl%0d_idx", r), int'(beat_idx[0]), int'(tbl[r].e_idx));
      step();
    end
    chk("tbl_spur", int'(spur[0]), 0);

    // Starvation with grant held low, clear while starving, clear after service
    force_gnt = '0;
    cmd_valid[0] = 1'b1; cmd_len[0] = 4'd0;
    step();
    cmd_valid[0] = 1'b0;
    step();
    repeat (7) step();
    chk("starve_before_timeout", int'(starve[0]), 0);
    step();
    chk("starve_at_timeout", int'(starve[0]), 1);
    chk("starve_req_held", int'(req[0]), 1);
    clr_err[0] = 1'b1;
    step();
    clr_err[0] = 1'b0;
    chk("starve_clr_while_set", int'(starve[0]), 1);
    force_gnt = 4'b0001;
    step();
    force_gnt = '0;
    clr_err[0] = 1'b1;
    step();
    clr_err[0] = 1'b0;
    chk("starve_cleared", int'(starve[0]), 0);
    force_gnt = 4'b0001;
    #1;
    chk("idle_grant_no_beat", int'(beat[0]), 0);
    step();
    force_gnt = '0;
    chk("spur_set", int'(spur[0]), 1);
    clr_err[0] = 1'b1;
    step();
    clr_err[0] = 1'b0;
    chk("spur_cleared", int'(spur[0]), 0);

    // Queue full on client 1: first command parks in REQ, then five more offered
    cmd_valid[1] = 1'b1; cmd_len[1] = 4'd0;
    step();
    for (int k = 1; k <= 4; k++) begin
      cmd_len[1] = 4'(k);
      #1;
      chk($sformatf("q_ready_push%0d", k), int'(cmd_ready[1]), 1);
      step();
    end
    cmd_len[1] = 4'd5;
    #1;
    chk("q_full_ready", int'(cmd_ready[1]), 0);
    repeat (3) step();
    chk("q_full_held", int'(cmd_ready[1]), 0);
    force_gnt = 4'b0010;
    step();
    force_gnt = '0;
    step();
    chk("q_full_in_idle", int'(cmd_ready[1]), 0);
    step();
    chk("q_ready_after_pop", int'(cmd_ready[1]), 1);
    step();
    cmd_valid[1] = 1'b0;
    #1;
    chk("q_fifth_accepted", int'(cmd_ready[1]), 0);

    // Asynchronous reset in the middle of a burst
    force_gnt = 4'b0001;
    cmd_valid[0] = 1'b1; cmd_len[0] = 4'd4;
    step();
    cmd_valid[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (beat[0] && beat_idx[0] == 4'd2) found = 1'b1;
      else step();
    end
    chk("rst_mid_found_idx2", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", int'(req[0]), 0);
    chk("rst_mid_done", int'(done[0]), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(cmd_ready), 15);
    chk("rst_mid_errs", int'({starve, spur}), 0);
    step();
    chk("rst_mid_no_done", int'(done[0]), 0);
    force_gnt = '0;
    force_en  = 1'b0;
    rst_n = 1'b1;
    step();

    // Contention: all four clients offer two-beat bursts together
    for (int i = 0; i < 4; i++) begin
      exp_len[i].delete(); beat_cnt[i] = 0; pend_done[i] = 1'b0; cmd_len[i] = 4'd1;
    end
    start_order.delete(); n_done = 0; n_acc = 0;
    mon_en = 1'b1;
    cmd_valid = 4'hF;
    step();
    cmd_valid = '0;
    for (int n = 0; n < 80 && n_done < 4; n++) step();
    chk("cont_done_count", n_done, 4);
    chk("cont_order_len", start_order.size(), 4);
    for (int i = 0; i < 4 && i < start_order.size(); i++)
      chk($sformatf("cont_order%0d", i), start_order[i], i);

    // Random traffic against the scoreboard
    for (int i = 0; i < 4; i++) acc[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!cmd_valid[i] || acc[i]) begin
          cmd_valid[i] = ($urandom_range(0, 2) == 0);
          cmd_len[i]   = 4'($urandom_range(0, 5));
        end
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) acc[i] = cmd_valid[i] && cmd_ready[i];
      step();
    end
    cmd_valid = '0;
    for (int n = 0; n < 400 && busy != 4'b0; n++) step();
    step();
    chk("rand_drain_busy", int'(busy), 0);
    chk("rand_all_done", n_done, n_acc);
    for (int i = 0; i < 4; i++) chk($sformatf("rand_queue_empty_c%0d", i), exp_len[i].size(), 0);
    chk("rand_no_spur", int'(spur), 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
